dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters:
  - port 0: CPU load/store stage;
  - port 1: watermark/debug access port.
- Req/ack handshake per port and round-robin arbitration.
- Sequences each access into the memory's opcode/address/value bus and registers the returned word.
- Sits between the execute/memory stage and the data memory.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_arbiter_rr_arb2.sv | 43 ++++
 rtl/dmem_arbiter.sv | 210 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared opcodes, state encoding and helpers for the data-memory
//               arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Default geometry: 256-word memory, 32-bit words
    localparam int AW_DEF = 8;
    localparam int DW_DEF = 32;

    // Opcodes understood by the data memory
    localparam logic [5:0] OPC_LW  = 6'b100011;
    localparam logic [5:0] OPC_SW  = 6'b101011;
    localparam logic [5:0] OPC_NOP = 6'b000000;

    // Access sequencer states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // A word address is decodable only when every bit above the low aw bits is zero
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return ((addr >> aw) == 32'd0);
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-requester round-robin arbiter. Produces a one-hot grant
//               from the requests and the last-grant pointer; the pointer
//               moves to the winner when the enable strobe is high.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2
    import dmem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_req,
    input  logic       i_en,
    output logic [1:0] o_grant
);

    // Index of the most recent winner; reset to 1 so port 0 wins the first tie
    logic r_last;

    // One-hot grant: a lone requester wins, a tie goes to the port that did not win last
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Pointer follows the winner whenever a grant is actually taken
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last <= 1'b1;
        end else if (i_en && (o_grant != 2'b00)) begin
            r_last <= o_grant[1];
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the CPU load/store
//               stage (port 0) and the watermark/debug port (port 1). Each
//               granted access runs IDLE -> ACCESS -> DONE: the memory bus is
//               driven for one cycle, the read word is captured, and the
//               winner receives a one-cycle ack.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    // port 0: CPU load/store stage
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [31:0]   r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_ack,
    output logic          r0_err,
    output logic [DW-1:0] r0_rdata,
    // port 1: watermark/debug access
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [31:0]   r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_ack,
    output logic          r1_err,
    output logic [DW-1:0] r1_rdata,
    // data memory bus
    output logic [5:0]    mem_opcode,
    output logic [31:0]   mem_address,
    output logic [DW-1:0] mem_value,
    input  logic [DW-1:0] mem_result,
    output logic          busy
);

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t        r_state;
    state_t        w_next;

    logic [1:0]    w_req;
    logic [1:0]    w_grant;
    logic          w_take;

    logic          w_we;
    logic [31:0]   w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_in_range;

    logic [1:0]    r_sel;
    logic          r_we;
    logic          r_in_range;

    logic [5:0]    r_mem_opcode;
    logic [31:0]   r_mem_address;
    logic [DW-1:0] r_mem_value;

    logic          r_r0_ack;
    logic          r_r0_err;
    logic [DW-1:0] r_r0_rdata;
    logic          r_r1_ack;
    logic          r_r1_err;
    logic [DW-1:0] r_r1_rdata;

    // ------------------------------------------------------------------------
    // Arbitration: requests are only considered while idle
    // ------------------------------------------------------------------------
    assign w_req  = {r1_req, r0_req};
    assign w_take = (r_state == IDLE) && (w_req != 2'b00);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .i_req   (w_req),
        .i_en    (w_take),
        .o_grant (w_grant)
    );

    // Winner's payload, selected by the one-hot grant
    assign w_we       = w_grant[1] ? r1_we    : r0_we;
    assign w_addr     = w_grant[1] ? r1_addr  : r0_addr;
    assign w_wdata    = w_grant[1] ? r1_wdata : r0_wdata;
    assign w_in_range = addr_in_range(w_addr, AW);

    // ------------------------------------------------------------------------
    // Access sequencer
    // ------------------------------------------------------------------------

    // State register; reset dominates any pending request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state: wait for a request, then exactly one ACCESS and one DONE cycle
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = (w_req != 2'b00) ? ACCESS : IDLE;
            ACCESS:  w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Memory bus: loaded on the grant edge so it is stable for the whole
    // ACCESS cycle; opcode falls back to NOP at every other edge while the
    // address and value keep their last contents.
    // ------------------------------------------------------------------------

    // Latch the winner's request and drive the memory bus for the ACCESS cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel         <= 2'b00;
            r_we          <= 1'b0;
            r_in_range    <= 1'b0;
            r_mem_opcode  <= OPC_NOP;
            r_mem_address <= 32'd0;
            r_mem_value   <= '0;
        end else begin
            r_mem_opcode <= OPC_NOP;
            if (w_take) begin
                r_sel         <= w_grant;
                r_we          <= w_we;
                r_in_range    <= w_in_range;
                r_mem_address <= w_addr;
                r_mem_value   <= w_wdata;
                // An undecodable address never reaches the memory as a real access
                if (w_in_range) begin
                    r_mem_opcode <= w_we ? OPC_SW : OPC_LW;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Responses: the edge closing ACCESS raises ack for one cycle (DONE) and
    // updates rdata for loads or out-of-range accesses; stores leave it alone.
    // ------------------------------------------------------------------------

    // Port 0 response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r0_ack   <= 1'b0;
            r_r0_err   <= 1'b0;
            r_r0_rdata <= '0;
        end else begin
            r_r0_ack <= 1'b0;
            r_r0_err <= 1'b0;
            if ((r_state == ACCESS) && r_sel[0]) begin
                r_r0_ack <= 1'b1;
                r_r0_err <= ~r_in_range;
                if (!r_in_range) begin
                    r_r0_rdata <= '0;
                end else if (!r_we) begin
                    r_r0_rdata <= mem_result;
                end
            end
        end
    end

    // Port 1 response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_r1_ack   <= 1'b0;
            r_r1_err   <= 1'b0;
            r_r1_rdata <= '0;
        end else begin
            r_r1_ack <= 1'b0;
            r_r1_err <= 1'b0;
            if ((r_state == ACCESS) && r_sel[1]) begin
                r_r1_ack <= 1'b1;
                r_r1_err <= ~r_in_range;
                if (!r_in_range) begin
                    r_r1_rdata <= '0;
                end else if (!r_we) begin
                    r_r1_rdata <= mem_result;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign r0_ack      = r_r0_ack;
    assign r0_err      = r_r0_err;
    assign r0_rdata    = r_r0_rdata;
    assign r1_ack      = r_r1_ack;
    assign r1_err      = r_r1_err;
    assign r1_rdata    = r_r1_rdata;
    assign mem_opcode  = r_mem_opcode;
    assign mem_address = r_mem_address;
    assign mem_value   = r_mem_value;
    assign busy        = (r_state != IDLE);

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_arbiter
// Description : Directed self-checking bench for dmem_arbiter with a 256-word
//               behavioural memory (negedge write, combinational read).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0;
    logic        r0_ack, r0_err;
    logic [31:0] r0_rdata;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [31:0] r1_addr = 32'd0, r1_wdata = 32'd0;
    logic        r1_ack, r1_err;
    logic [31:0] r1_rdata;
    logic [5:0]  mem_opcode;
    logic [31:0] mem_address, mem_value, mem_result;
    logic        busy;

    logic [31:0] tb_mem [0:255];

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.AW(8), .DW(32)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_ack(r0_ack), .r0_err(r0_err), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_ack(r1_ack), .r1_err(r1_err), .r1_rdata(r1_rdata),
        .mem_opcode(mem_opcode), .mem_address(mem_address), .mem_value(mem_value),
        .mem_result(mem_result), .busy(busy)
    );

    always #5 clk = ~clk;

    // Memory model: store commits at the negedge inside the ACCESS cycle
    always @(negedge clk) begin
        if (mem_opcode == OPC_SW) tb_mem[mem_address[7:0]] <= mem_value;
    end
    assign mem_result = tb_mem[mem_address[7:0]];

    // Stimulus helper (no checking): call just after a posedge with the DUT idle
    task automatic issue(input int port, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int lat,
                         output logic [31:0] rdata, output logic err,
                         output logic [5:0] acc_op, output logic stray_op,
                         output logic other_ack, output logic timeout);
        lat = 0; rdata = 32'd0; err = 1'b0; acc_op = OPC_NOP;
        stray_op = 1'b0; other_ack = 1'b0; timeout = 1'b1;
        if (port == 0) begin
            r0_req = 1'b1; r0_we = we; r0_addr = addr; r0_wdata = wdata;
        end else begin
            r1_req = 1'b1; r1_we = we; r1_addr = addr; r1_wdata = wdata;
        end
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 2) acc_op = mem_opcode;
            else if (mem_opcode != OPC_NOP) stray_op = 1'b1;
            if ((port == 0 && r1_ack) || (port == 1 && r0_ack)) other_ack = 1'b1;
            if ((port == 0) ? r0_ack : r1_ack) begin
                lat = n;
                rdata = (port == 0) ? r0_rdata : r1_rdata;
                err = (port == 0) ? r0_err : r1_err;
                timeout = 1'b0;
                break;
            end
        end
        @(posedge clk); #1;
        if (port == 0) r0_req = 1'b0; else r1_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd5; r0_wdata = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (r0_ack !== 1'b0 || r1_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b%b want 00", r1_ack, r0_ack); end
        checks++; if (r0_err !== 1'b0 || r1_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b%b want 00", r1_err, r0_err); end
        checks++; if (r0_rdata !== 32'd0 || r1_rdata !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", r0_rdata, r1_rdata); end
        checks++; if (mem_opcode !== OPC_NOP) begin errors++; $display("FAIL reset_opcode: got %b want %b", mem_opcode, OPC_NOP); end
        checks++; if (mem_address !== 32'd0 || mem_value !== 32'd0) begin errors++; $display("FAIL reset_bus: got addr %h val %h want 0/0", mem_address, mem_value); end
        @(posedge clk); #1;
        rst = 1'b0; r0_req = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_req_ignored: busy got %b want 0", busy); end
        checks++; if (tb_mem[5] !== 32'h10000005) begin errors++; $display("FAIL reset_no_store: mem[5] got %h want 10000005", tb_mem[5]); end
    endtask

    task automatic test_contention();
        int nacks = 0;
        int order [6];
        int cyc [6];
        logic [31:0] rd [6];
        logic both = 1'b0, consec = 1'b0, prev_any = 1'b0;
        @(posedge clk); #1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd5;
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 32'd3;
        for (int c = 1; c <= 40 && nacks < 6; c++) begin
            @(negedge clk);
            if (r0_ack && r1_ack) both = 1'b1;
            if ((r0_ack || r1_ack) && prev_any) consec = 1'b1;
            if (r0_ack || r1_ack) begin
                order[nacks] = r1_ack ? 1 : 0;
                rd[nacks] = r1_ack ? r1_rdata : r0_rdata;
                cyc[nacks] = c;
                nacks++;
            end
            prev_any = r0_ack || r1_ack;
        end
        @(posedge clk); #1;
        r0_req = 1'b0; r1_req = 1'b0;
        checks++; if (nacks !== 6) begin errors++; $display("FAIL contend_count: got %0d acks want 6", nacks); end
        for (int i = 0; i < nacks; i++) begin
            checks++; if (order[i] !== (i % 2)) begin errors++; $display("FAIL contend_order[%0d]: got port %0d want %0d", i, order[i], i % 2); end
        end
        checks++; if (both !== 1'b0) begin errors++; $display("FAIL contend_both_ack: got %b want 0", both); end
        checks++; if (consec !== 1'b0) begin errors++; $display("FAIL contend_ack_width: got multi-cycle ack %b want 0", consec); end
        if (nacks == 6) begin
            checks++; if (cyc[5] - cyc[0] !== 15) begin errors++; $display("FAIL contend_spacing: got %0d cycles want 15", cyc[5] - cyc[0]); end
            checks++; if (rd[0] !== 32'h10000005 || rd[1] !== 32'h10000003) begin errors++; $display("FAIL contend_rdata: got %h/%h want 10000005/10000003", rd[0], rd[1]); end
        end
    endtask

    task automatic test_store_load();
        int lat; logic [31:0] rd; logic err, stray, oth, to; logic [5:0] op;
        @(posedge clk); #1;
        issue(0, 1'b1, 32'd5, 32'hDEADBEEF, lat, rd, err, op, stray, oth, to);
        checks++; if (to !== 1'b0 || lat !== 3) begin errors++; $display("FAIL st_latency: got %0d timeout %b want 3", lat, to); end
        checks++; if (op !== OPC_SW || stray !== 1'b0) begin errors++; $display("FAIL st_opcode: got %b stray %b want %b stray 0", op, stray, OPC_SW); end
        checks++; if (err !== 1'b0 || rd !== 32'h10000005) begin errors++; $display("FAIL st_resp: got err %b rdata %h want 0/10000005", err, rd); end
        checks++; if (tb_mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL st_mem: got %h want deadbeef", tb_mem[5]); end
        issue(0, 1'b0, 32'd5, 32'd0, lat, rd, err, op, stray, oth, to);
        checks++; if (to !== 1'b0 || lat !== 3) begin errors++; $display("FAIL ld_latency: got %0d timeout %b want 3", lat, to); end
        checks++; if (op !== OPC_LW || stray !== 1'b0) begin errors++; $display("FAIL ld_opcode: got %b stray %b want %b stray 0", op, stray, OPC_LW); end
        checks++; if (rd !== 32'hDEADBEEF || err !== 1'b0) begin errors++; $display("FAIL ld_resp: got rdata %h err %b want deadbeef/0", rd, err); end
        checks++; if (oth !== 1'b0) begin errors++; $display("FAIL ld_other_ack: got %b want 0", oth); end
        @(negedge clk);
        checks++; if (r0_ack !== 1'b0 || r0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ld_hold: got ack %b rdata %h want 0/deadbeef", r0_ack, r0_rdata); end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic err, stray, oth, to; logic [5:0] op;
        @(posedge clk); #1;
        issue(1, 1'b0, 32'h100, 32'd0, lat, rd, err, op, stray, oth, to);
        checks++; if (to !== 1'b0 || lat !== 3) begin errors++; $display("FAIL oor_latency: got %0d timeout %b want 3", lat, to); end
        checks++; if (err !== 1'b1 || rd !== 32'd0) begin errors++; $display("FAIL oor_resp: got err %b rdata %h want 1/0", err, rd); end
        checks++; if (op !== OPC_NOP || stray !== 1'b0) begin errors++; $display("FAIL oor_opcode: got %b stray %b want %b", op, stray, OPC_NOP); end
        checks++; if (tb_mem[0] !== 32'h10000000) begin errors++; $display("FAIL oor_mem0: got %h want 10000000", tb_mem[0]); end
        issue(1, 1'b1, 32'h105, 32'hFFFFFFFF, lat, rd, err, op, stray, oth, to);
        checks++; if (err !== 1'b1 || op !== OPC_NOP) begin errors++; $display("FAIL oor_store: got err %b op %b want 1/%b", err, op, OPC_NOP); end
        checks++; if (tb_mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL oor_store_mem: got %h want deadbeef", tb_mem[5]); end
    endtask

    task automatic test_cross_port();
        int lat; logic [31:0] rd; logic err, stray, oth, to; logic [5:0] op;
        @(posedge clk); #1;
        issue(1, 1'b1, 32'd7, 32'h12345678, lat, rd, err, op, stray, oth, to);
        checks++; if (to !== 1'b0 || err !== 1'b0 || op !== OPC_SW) begin errors++; $display("FAIL cross_store: got to %b err %b op %b want 0/0/%b", to, err, op, OPC_SW); end
        issue(0, 1'b0, 32'd7, 32'd0, lat, rd, err, op, stray, oth, to);
        checks++; if (to !== 1'b0 || rd !== 32'h12345678 || err !== 1'b0) begin errors++; $display("FAIL cross_load: got rdata %h err %b want 12345678/0", rd, err); end
    endtask

    task automatic test_reset_mid();
        int lat; logic [31:0] rd; logic err, stray, oth, to; logic [5:0] op;
        logic late_ack = 1'b0;
        @(posedge clk); #1;
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 32'd9; r0_wdata = 32'hA5A5A5A5;
        @(posedge clk); #1;
        @(negedge clk);
        checks++; if (busy !== 1'b1 || mem_opcode !== OPC_SW) begin errors++; $display("FAIL rmid_access: got busy %b op %b want 1/%b", busy, mem_opcode, OPC_SW); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; r0_req = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || r0_ack !== 1'b0 || r1_ack !== 1'b0) begin errors++; $display("FAIL rmid_state: got busy %b acks %b%b want 0/00", busy, r1_ack, r0_ack); end
        checks++; if (mem_opcode !== OPC_NOP || mem_address !== 32'd0 || mem_value !== 32'd0) begin errors++; $display("FAIL rmid_bus: got op %b addr %h val %h want nop/0/0", mem_opcode, mem_address, mem_value); end
        checks++; if (r0_rdata !== 32'd0) begin errors++; $display("FAIL rmid_rdata: got %h want 0", r0_rdata); end
        checks++; if (tb_mem[9] !== 32'hA5A5A5A5) begin errors++; $display("FAIL rmid_commit: got %h want a5a5a5a5", tb_mem[9]); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (r0_ack) late_ack = 1'b1;
        end
        checks++; if (late_ack !== 1'b0) begin errors++; $display("FAIL rmid_no_ack: got %b want 0", late_ack); end
        @(posedge clk); #1;
        issue(0, 1'b0, 32'd9, 32'd0, lat, rd, err, op, stray, oth, to);
        checks++; if (to !== 1'b0 || rd !== 32'hA5A5A5A5) begin errors++; $display("FAIL rmid_reload: got %h timeout %b want a5a5a5a5", rd, to); end
    endtask

    task automatic test_back_to_back();
        logic [5:0] exp_busy = 6'b110110;
        logic [5:0] exp_ack  = 6'b100100;
        logic [5:0] got_busy = 6'd0;
        logic [5:0] got_ack  = 6'd0;
        @(posedge clk); #1;
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 32'd7;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            got_busy[c] = busy;
            got_ack[c]  = r0_ack;
        end
        @(posedge clk); #1;
        r0_req = 1'b0;
        for (int c = 0; c < 6; c++) begin
            checks++; if (got_busy[c] !== exp_busy[c]) begin errors++; $display("FAIL b2b_busy[%0d]: got %b want %b", c, got_busy[c], exp_busy[c]); end
        end
        checks++; if (got_ack !== exp_ack) begin errors++; $display("FAIL b2b_ack: got %b want %b", got_ack, exp_ack); end
        checks++; if (r0_rdata !== 32'h12345678) begin errors++; $display("FAIL b2b_rdata: got %h want 12345678", r0_rdata); end
    endtask

    // Global bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) tb_mem[i] = 32'h10000000 + i;
        test_reset();
        test_contention();
        test_store_load();
        test_out_of_range();
        test_cross_port();
        test_reset_mid();
        test_back_to_back();
        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
